bf_relax_engine: RTL and testbench

- Bellman-Ford relaxation stage that runs directly upstream of cycle detection in the arbitrage pipeline.
- Initialises the vertex matrix, then performs NODES-1 relaxation passes over every adjacency-matrix edge, writing updated {pred, weight} words back to the vertex matrix.
- Raises relax_done when finished; top level turns that into the one-cycle start pulse of the cycle-detect stage, which reads the same memories.

---
 rtl/bf_relax_engine.sv | 194 +++++++++++++++++++
 tb/tb_bf_relax_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_relax_engine.sv
// Bellman-Ford relaxation stage: initialises the vertex matrix, then runs
// NODES-1 in-place relaxation passes over every adjacency-matrix edge.
// Optional feature macro: BF_EARLY_EXIT_EN (stop after the first pass with no update).
module bf_relax_engine #(
  parameter int NODES    = 32,
  parameter int PRED_W   = 5,
  parameter int WEIGHT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         relax_start,
  input  logic [WEIGHT_W-1:0]          adjmat_q,
  input  logic [PRED_W+WEIGHT_W-1:0]   vertmat_q_a,
  input  logic [PRED_W+WEIGHT_W-1:0]   vertmat_q_b,
  output logic [PRED_W-1:0]            adjmat_row_addr,
  output logic [PRED_W-1:0]            adjmat_col_addr,
  output logic [PRED_W-1:0]            vertmat_addr_a,
  output logic [PRED_W-1:0]            vertmat_addr_b,
  output logic [PRED_W+WEIGHT_W-1:0]   vertmat_data_b,
  output logic                         vertmat_we_b,
  output logic                         relax_busy,
  output logic                         relax_done
);

  localparam logic [PRED_W-1:0] LAST_IDX  = PRED_W'(NODES - 1);
  localparam logic [PRED_W-1:0] LAST_PASS = PRED_W'(NODES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_RELAX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [PRED_W-1:0] i_idx, j_idx, pass_idx, init_idx;

  logic [WEIGHT_W-1:0]        src_w, dst_w, sat_w;
  logic signed [WEIGHT_W:0]   sum, dst_ext;
  logic                       update;
  logic                       last_j, last_i, last_edge, last_pass, pass_clean;

  // Predecessor fields of the read words play no part in relaxation.
  logic unused_pred;
  assign unused_pred = ^{vertmat_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W],
                         vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W]};

  assign adjmat_row_addr = i_idx;
  assign adjmat_col_addr = j_idx;
  assign vertmat_addr_a  = i_idx;
  assign vertmat_addr_b  = (state == S_INIT) ? init_idx : j_idx;

  assign last_j    = (j_idx == LAST_IDX);
  assign last_i    = (i_idx == LAST_IDX);
  assign last_edge = last_j && last_i;
  assign last_pass = (pass_idx == LAST_PASS);

  // Relaxation datapath: widened signed sum, update decision and saturation.
  always_comb begin
    src_w   = vertmat_q_a[WEIGHT_W-1:0];
    dst_w   = vertmat_q_b[WEIGHT_W-1:0];
    sum     = {src_w[WEIGHT_W-1], src_w} + {adjmat_q[WEIGHT_W-1], adjmat_q};
    dst_ext = {dst_w[WEIGHT_W-1], dst_w};
    update  = (state == S_RELAX) && (adjmat_q != '0) && (i_idx != j_idx) && (sum < dst_ext);
    if (sum[WEIGHT_W] != sum[WEIGHT_W-1])
      sat_w = sum[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}};
    else
      sat_w = sum[WEIGHT_W-1:0];
  end

`ifdef BF_EARLY_EXIT_EN
  logic dirty;

  // Per-pass dirty flag: cleared at pass start, set by any update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dirty <= 1'b0;
    else if (state == S_INIT)
      dirty <= 1'b0;
    else if (state == S_RELAX) begin
      if (last_edge)
        dirty <= 1'b0;
      else if (update)
        dirty <= 1'b1;
    end
  end

  assign pass_clean = !(dirty || update);
`else
  assign pass_clean = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic and memory write/status outputs.
  always_comb begin
    state_next     = state;
    vertmat_we_b   = 1'b0;
    vertmat_data_b = '0;
    relax_busy     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (relax_start)
          state_next = S_INIT;
      end
      S_INIT: begin
        relax_busy     = 1'b1;
        vertmat_we_b   = 1'b1;
        vertmat_data_b = {init_idx, {WEIGHT_W{1'b0}}};
        if (init_idx == LAST_IDX)
          state_next = (NODES == 1) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        relax_busy = 1'b1;
        state_next = S_RELAX;
      end
      S_RELAX: begin
        relax_busy = 1'b1;
        if (update) begin
          vertmat_we_b   = 1'b1;
          vertmat_data_b = {i_idx, sat_w};
        end
        if (last_edge && (last_pass || pass_clean))
          state_next = S_DONE;
        else
          state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Index counters: init index in INIT, then j fastest, i, pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_idx <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      pass_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (relax_start) begin
            init_idx <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            pass_idx <= '0;
          end
        end
        S_INIT: begin
          if (init_idx == LAST_IDX) begin
            init_idx <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            pass_idx <= '0;
          end else begin
            init_idx <= init_idx + PRED_W'(1);
          end
        end
        S_RELAX: begin
          if (!last_j)
            j_idx <= j_idx + PRED_W'(1);
          else begin
            j_idx <= '0;
            if (!last_i)
              i_idx <= i_idx + PRED_W'(1);
            else begin
              i_idx    <= '0;
              pass_idx <= pass_idx + PRED_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Done level: rises the cycle after DONE is entered, drops as soon as a
  // restart is sampled in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      relax_done <= 1'b0;
    else
      relax_done <= (state == S_DONE) && !relax_start;
  end

endmodule

// File: tb/tb_bf_relax_engine.sv
// Scoreboard bench for bf_relax_engine: 32-bit and 8-bit instances with
// behavioural synchronous memories; writes and done-rise times are checked
// against queued expectations by a negedge monitor.
module tb_bf_relax_engine;

`ifdef BF_EARLY_EXIT_EN
  localparam int LAT_ZERO = 37;
  localparam int LAT_G    = 69;
  localparam int RST_AT   = 50;
`else
  localparam int LAT_ZERO = 101;
  localparam int LAT_G    = 101;
  localparam int RST_AT   = 80;
`endif
  localparam int LAT_S = 101;

  typedef struct { logic [1:0] a; logic [33:0] d; } wr_t;
  typedef struct { logic [1:0] a; logic [9:0]  d; } wr8_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start, start8;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance and its memories
  logic [31:0] adj [16];
  logic [33:0] vm  [4];
  logic [31:0] adj_q;
  logic [33:0] vq_a, vq_b, data_b;
  logic [1:0]  row, col, addr_a, addr_b;
  logic        we_b, busy, done;

  bf_relax_engine #(.NODES(4), .PRED_W(2), .WEIGHT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .relax_start(start),
    .adjmat_q(adj_q), .vertmat_q_a(vq_a), .vertmat_q_b(vq_b),
    .adjmat_row_addr(row), .adjmat_col_addr(col),
    .vertmat_addr_a(addr_a), .vertmat_addr_b(addr_b),
    .vertmat_data_b(data_b), .vertmat_we_b(we_b),
    .relax_busy(busy), .relax_done(done)
  );

  always @(posedge clk) begin
    adj_q <= adj[{row, col}];
    vq_a  <= vm[addr_a];
    vq_b  <= vm[addr_b];
    if (we_b) vm[addr_b] <= data_b;
  end

  // 8-bit instance for saturation
  logic [7:0]  adj8 [16];
  logic [9:0]  vm8  [4];
  logic [7:0]  adj8_q;
  logic [9:0]  vq8_a, vq8_b, data8_b;
  logic [1:0]  row8, col8, addr8_a, addr8_b;
  logic        we8_b, busy8, done8;

  bf_relax_engine #(.NODES(4), .PRED_W(2), .WEIGHT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .relax_start(start8),
    .adjmat_q(adj8_q), .vertmat_q_a(vq8_a), .vertmat_q_b(vq8_b),
    .adjmat_row_addr(row8), .adjmat_col_addr(col8),
    .vertmat_addr_a(addr8_a), .vertmat_addr_b(addr8_b),
    .vertmat_data_b(data8_b), .vertmat_we_b(we8_b),
    .relax_busy(busy8), .relax_done(done8)
  );

  always @(posedge clk) begin
    adj8_q <= adj8[{row8, col8}];
    vq8_a  <= vm8[addr8_a];
    vq8_b  <= vm8[addr8_b];
    if (we8_b) vm8[addr8_b] <= data8_b;
  end

  // Scoreboard queues
  wr_t  exp_w[$];
  wr8_t exp_w8[$];
  int   exp_done[$];
  int   exp_done8[$];

  wr_t  ew;
  wr8_t ew8;
  int   ed;
  logic prev_done = 1'b0, prev_done8 = 1'b0;

  // Monitor: compare every write and every done rise against the queues.
  always @(negedge clk) begin
    if (reset_n && we_b) begin
      checks++;
      if (exp_w.size() == 0) begin
        failures++;
        $display("FAIL wr32_unexpected cyc=%0d addr=%0d data=%h", cyc, addr_b, data_b);
      end else begin
        ew = exp_w.pop_front();
        if (ew.a !== addr_b || ew.d !== data_b) begin
          failures++;
          $display("FAIL wr32 cyc=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                   cyc, addr_b, data_b, ew.a, ew.d);
        end
      end
    end
    if (reset_n && we8_b) begin
      checks++;
      if (exp_w8.size() == 0) begin
        failures++;
        $display("FAIL wr8_unexpected cyc=%0d addr=%0d data=%h", cyc, addr8_b, data8_b);
      end else begin
        ew8 = exp_w8.pop_front();
        if (ew8.a !== addr8_b || ew8.d !== data8_b) begin
          failures++;
          $display("FAIL wr8 cyc=%0d got addr=%0d data=%h expected addr=%0d data=%h",
                   cyc, addr8_b, data8_b, ew8.a, ew8.d);
        end
      end
    end
    if (done && !prev_done) begin
      checks++;
      if (exp_done.size() == 0) begin
        failures++;
        $display("FAIL done32_unexpected cyc=%0d", cyc);
      end else begin
        ed = exp_done.pop_front();
        if (ed != cyc) begin
          failures++;
          $display("FAIL done32_time got cyc=%0d expected cyc=%0d", cyc, ed);
        end
      end
    end
    if (done8 && !prev_done8) begin
      checks++;
      if (exp_done8.size() == 0) begin
        failures++;
        $display("FAIL done8_unexpected cyc=%0d", cyc);
      end else begin
        ed = exp_done8.pop_front();
        if (ed != cyc) begin
          failures++;
          $display("FAIL done8_time got cyc=%0d expected cyc=%0d", cyc, ed);
        end
      end
    end
    prev_done  <= done;
    prev_done8 <= done8;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic push_init;
    for (int k = 0; k < 4; k++) exp_w.push_back('{a: 2'(k), d: {2'(k), 32'h0}});
  endtask

  task automatic push_graph;
    push_init();
    exp_w.push_back('{a: 2'd1, d: {2'd0, 32'hFFFF_FFFB}});
    exp_w.push_back('{a: 2'd2, d: {2'd1, 32'hFFFF_FFF8}});
  endtask

  // Pulse start for one cycle; expected done-rise cycle is queued here.
  task automatic pulse(input bit narrow, input int lat);
    @(negedge clk);
    if (narrow) begin
      start8 = 1'b1;
      exp_done8.push_back(cyc + 1 + lat);
    end else begin
      start = 1'b1;
      exp_done.push_back(cyc + 1 + lat);
    end
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_done(input bit narrow, input string name);
    int n;
    n = 0;
    while (n < 300 && !(narrow ? done8 : done)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=not_done expected=done within 300 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic check_graph_mem(input string tag);
    chk({tag, "_v0"}, 64'(vm[0]), 64'({2'd0, 32'h0}));
    chk({tag, "_v1"}, 64'(vm[1]), 64'({2'd0, 32'hFFFF_FFFB}));
    chk({tag, "_v2"}, 64'(vm[2]), 64'({2'd1, 32'hFFFF_FFF8}));
    chk({tag, "_v3"}, 64'(vm[3]), 64'({2'd3, 32'h0}));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    start8  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      adj[k]  = '0;
      adj8[k] = '0;
    end
    #2;
    chk("rst_we",   64'(we_b),   64'd0);
    chk("rst_done", 64'(done),   64'd0);
    chk("rst_busy", 64'(busy),   64'd0);
    chk("rst_data", 64'(data_b), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // All-zero graph: only INIT writes
    push_init();
    pulse(1'b0, LAT_ZERO);
    wait_done(1'b0, "zero");
    for (int k = 0; k < 4; k++) chk("zero_vk", 64'(vm[k]), 64'({2'(k), 32'h0}));

    // Negative chain 0->1->2, with an ignored start pulse during RELAX
    adj[4'h1] = 32'hFFFF_FFFB;
    adj[4'h6] = 32'hFFFF_FFFD;
    push_graph();
    pulse(1'b0, LAT_G);
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, "graph");
    check_graph_mem("graph");

    // Start while in DONE: INIT begins on the next cycle
    push_graph();
    @(negedge clk);
    start = 1'b1;
    exp_done.push_back(cyc + 1 + LAT_G);
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", 64'(done),   64'd0);
    chk("restart_busy", 64'(busy),   64'd1);
    chk("restart_we",   64'(we_b),   64'd1);
    chk("restart_addr", 64'(addr_b), 64'd0);
    wait_done(1'b0, "restart");

    // Asynchronous reset mid-run, then a clean rerun
    push_graph();
    pulse(1'b0, LAT_G);
    repeat (RST_AT) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_we",   64'(we_b), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_done.delete();
    exp_w.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_idle", 64'(busy), 64'd0);
    push_graph();
    pulse(1'b0, LAT_G);
    wait_done(1'b0, "rerun");
    check_graph_mem("rerun");

    // 8-bit saturation and self-loop
    adj8[4'h1] = 8'h80;
    adj8[4'h6] = 8'h80;
    adj8[4'hF] = 8'hFF;
    for (int k = 0; k < 4; k++) exp_w8.push_back('{a: 2'(k), d: {2'(k), 8'h00}});
    exp_w8.push_back('{a: 2'd1, d: {2'd0, 8'h80}});
    for (int p = 0; p < 3; p++) exp_w8.push_back('{a: 2'd2, d: {2'd1, 8'h80}});
    pulse(1'b1, LAT_S);
    wait_done(1'b1, "sat");
    chk("sat_v1", 64'(vm8[1]), 64'({2'd0, 8'h80}));
    chk("sat_v2", 64'(vm8[2]), 64'({2'd1, 8'h80}));
    chk("sat_v3", 64'(vm8[3]), 64'({2'd3, 8'h00}));

    repeat (3) @(negedge clk);
    chk("left_w32",    64'(exp_w.size()),     64'd0);
    chk("left_w8",     64'(exp_w8.size()),    64'd0);
    chk("left_done32", 64'(exp_done.size()),  64'd0);
    chk("left_done8",  64'(exp_done8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
